fpu_comp_arb: RTL and testbench

//  Shares one fp16 comparator datapath (existing fpuComp16) among NUM_REQ requesters.

---
 rtl/fpu_pkg.sv | 32 +++
 rtl/fpuComp16.sv | 32 +++
 rtl/fpu_rr_arb.sv | 46 ++++
 rtl/fpu_comp_arb.sv | 191 +++++++++++++++++++
 tb/tb_fpu_comp_arb.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared fp16 types for the scalar FPU: fp16_t, comparator op codes and
// canonical quiet NaN, plus small classification helpers.
package fpu_pkg;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] frac;
    } fp16_t;

    typedef enum logic [2:0] {
        CMP_LT  = 3'd0,
        CMP_EQ  = 3'd1,
        CMP_GT  = 3'd2,
        CMP_LE  = 3'd3,
        CMP_GE  = 3'd4,
        CMP_NE  = 3'd5,
        CMP_MIN = 3'd6,
        CMP_MAX = 3'd7
    } cmp_op_t;

    localparam logic [15:0] FP16_QNAN = 16'h7E00;

    function automatic logic isNan(input fp16_t x);
        return (x.exp == 5'h1F) && (x.frac != 10'h000);
    endfunction

    function automatic logic isZero(input fp16_t x);
        return (x.exp == 5'h00) && (x.frac == 10'h000);
    endfunction

endpackage

// File: rtl/fpuComp16.sv
// Plain fp16 comparator: orders operands as raw sign/magnitude words.
// No zero or NaN special-casing; callers layer that on top.
module fpuComp16
    import fpu_pkg::*;
(
    input  fp16_t a,
    input  fp16_t b,
    output logic  lt,
    output logic  eq,
    output logic  gt
);

    logic [14:0] magA;
    logic [14:0] magB;

    assign magA = {a.exp, a.frac};
    assign magB = {b.exp, b.frac};

    always_comb begin
        eq = (a == b);
        if (a.sign != b.sign) begin
            lt = a.sign;
        end else if (!a.sign) begin
            lt = (magA < magB);
        end else begin
            // Both negative: the larger magnitude is the smaller value
            lt = (magA > magB);
        end
        gt = ~lt & ~eq;
    end

endmodule

// File: rtl/fpu_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant searched from the pointer,
// pointer moves past the winner only when the grant is actually taken.
module fpu_rr_arb #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clock,
    input  logic                       reset_L,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       advance,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grantIdx
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] ptrReg;

    always_comb begin
        int   idx;
        logic found;
        grant    = '0;
        grantIdx = '0;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptrReg) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grantIdx   = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            ptrReg <= '0;
        end else if (advance) begin
            ptrReg <= (grantIdx == ID_W'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
        end
    end

endmodule

// File: rtl/fpu_comp_arb.sv
// Shares one fpuComp16 among NUM_REQ requesters: round-robin grant, operand
// stage (s1), result stage (s2). NaN awareness is enabled by FPU_CMP_NAN_EN.
module fpu_comp_arb
    import fpu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 4
) (
    input  logic                             clock,
    input  logic                             reset_L,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0][15:0]         req_a,
    input  logic [NUM_REQ-1:0][15:0]         req_b,
    input  logic [NUM_REQ-1:0][2:0]          req_op,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]    req_tag,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]       rsp_id,
    output logic [TAG_W-1:0]                 rsp_tag,
    output logic                             rsp_flag,
    output logic [15:0]                      rsp_val,
    output logic                             rsp_unord
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic               s1Valid;
    fp16_t              s1A;
    fp16_t              s1B;
    cmp_op_t            s1Op;
    logic [TAG_W-1:0]   s1Tag;
    logic [ID_W-1:0]    s1Id;

    logic               s1Load;
    logic               s2Load;
    logic               handshake;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grantIdx;

    logic               rawLt;
    logic               rawEq;
    logic               rawGt;
    logic               bothZero;
    logic               ordLt;
    logic               ordEq;
    logic               ordGt;
    logic               flagNext;
    logic [15:0]        valNext;

    assign s2Load    = s1Valid & (~rsp_valid | rsp_ready);
    assign s1Load    = ~s1Valid | s2Load;
    assign handshake = s1Load & (|req_valid);

    fpu_rr_arb #(.NUM_REQ(NUM_REQ)) arb (
        .clock    (clock),
        .reset_L  (reset_L),
        .req      (req_valid),
        .advance  (handshake),
        .grant    (grant),
        .grantIdx (grantIdx)
    );

    // Held low during reset so nothing is offered while s1 cannot capture it
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = grant[gi] & s1Load & reset_L;
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            s1Valid <= 1'b0;
            s1A     <= '0;
            s1B     <= '0;
            s1Op    <= CMP_LT;
            s1Tag   <= '0;
            s1Id    <= '0;
        end else if (s1Load) begin
            s1Valid <= handshake;
            if (handshake) begin
                s1A   <= fp16_t'(req_a[grantIdx]);
                s1B   <= fp16_t'(req_b[grantIdx]);
                s1Op  <= cmp_op_t'(req_op[grantIdx]);
                s1Tag <= req_tag[grantIdx];
                s1Id  <= grantIdx;
            end
        end
    end

    fpuComp16 comp (
        .a  (s1A),
        .b  (s1B),
        .lt (rawLt),
        .eq (rawEq),
        .gt (rawGt)
    );

    // +0 and -0 differ only in sign, which the raw comparator orders
    assign bothZero = isZero(s1A) & isZero(s1B);
    assign ordLt    = rawLt & ~bothZero;
    assign ordEq    = rawEq | bothZero;
    assign ordGt    = rawGt & ~bothZero;

`ifdef FPU_CMP_NAN_EN
    logic nanA;
    logic nanB;
    logic unordNext;
    logic unordReg;

    assign nanA = isNan(s1A);
    assign nanB = isNan(s1B);
`endif

    always_comb begin
        flagNext = 1'b0;
        valNext  = '0;
        case (s1Op)
            CMP_LT:  flagNext = ordLt;
            CMP_EQ:  flagNext = ordEq;
            CMP_GT:  flagNext = ordGt;
            CMP_LE:  flagNext = ordLt | ordEq;
            CMP_GE:  flagNext = ordGt | ordEq;
            CMP_NE:  flagNext = ~ordEq;
            CMP_MIN: begin
                flagNext = ~ordGt;
                valNext  = flagNext ? s1A : s1B;
            end
            CMP_MAX: begin
                flagNext = ~ordLt;
                valNext  = flagNext ? s1A : s1B;
            end
            default: flagNext = 1'b0;
        endcase
`ifdef FPU_CMP_NAN_EN
        unordNext = nanA | nanB;
        if (unordNext) begin
            valNext = '0;
            case (s1Op)
                CMP_MIN, CMP_MAX: begin
                    if (nanA && nanB) begin
                        flagNext = 1'b0;
                        valNext  = FP16_QNAN;
                    end else if (nanA) begin
                        flagNext = 1'b0;
                        valNext  = s1B;
                    end else begin
                        flagNext = 1'b1;
                        valNext  = s1A;
                    end
                end
                CMP_NE:  flagNext = 1'b1;
                default: flagNext = 1'b0;
            endcase
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_tag   <= '0;
            rsp_flag  <= 1'b0;
            rsp_val   <= '0;
        end else if (s2Load) begin
            rsp_valid <= 1'b1;
            rsp_id    <= s1Id;
            rsp_tag   <= s1Tag;
            rsp_flag  <= flagNext;
            rsp_val   <= valNext;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef FPU_CMP_NAN_EN
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            unordReg <= 1'b0;
        end else if (s2Load) begin
            unordReg <= unordNext;
        end
    end

    assign rsp_unord = unordReg;
`else
    assign rsp_unord = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_comp_arb.sv
// Bench for fpu_comp_arb: directed steps then random traffic, checked against
// an integer-ordering reference model and a two-deep in-flight scoreboard.
module tb_fpu_comp_arb;

    localparam int NUM_REQ = 4;
    localparam int TAG_W   = 4;
    localparam int ID_W    = 2;

    logic                          clock = 1'b0;
    logic                          reset_L = 1'b0;
    logic [NUM_REQ-1:0]            reqValid = '0;
    logic [NUM_REQ-1:0]            reqReady;
    logic [NUM_REQ-1:0][15:0]      reqA = '0;
    logic [NUM_REQ-1:0][15:0]      reqB = '0;
    logic [NUM_REQ-1:0][2:0]       reqOp = '0;
    logic [NUM_REQ-1:0][TAG_W-1:0] reqTag = '0;
    logic                          rspValid;
    logic                          rspReady = 1'b0;
    logic [ID_W-1:0]               rspId;
    logic [TAG_W-1:0]              rspTag;
    logic                          rspFlag;
    logic [15:0]                   rspVal;
    logic                          rspUnord;

    always #5 clock = ~clock;

    fpu_comp_arb #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
        .clock     (clock),
        .reset_L   (reset_L),
        .req_valid (reqValid),
        .req_ready (reqReady),
        .req_a     (reqA),
        .req_b     (reqB),
        .req_op    (reqOp),
        .req_tag   (reqTag),
        .rsp_valid (rspValid),
        .rsp_ready (rspReady),
        .rsp_id    (rspId),
        .rsp_tag   (rspTag),
        .rsp_flag  (rspFlag),
        .rsp_val   (rspVal),
        .rsp_unord (rspUnord)
    );

    typedef struct {
        int          id;
        int          tag;
        bit          flag;
        logic [15:0] val;
        bit          unord;
        int          acc;
    } exp_t;

    exp_t expQ[$];
    int   cycleNo    = 0;
    int   rrPtr      = 0;
    int   compared   = 0;
    int   mismatched = 0;
    logic [15:0] specials [12] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00, 16'h7E01,
                                   16'hFE00, 16'h3C00, 16'hBC00, 16'h0001, 16'h8001, 16'h7BFF};

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] want);
        compared++;
        assert (obs === want) else begin
            mismatched++;
            $error("FAIL %s: observed %0h, expected %0h", name, obs, want);
        end
    endtask

    // Exact value in units of 2^-24; exp==31 patterns sit above every finite value
    function automatic longint ordKey(input logic [15:0] x);
        longint m;
        if (x[14:10] == 5'h1F)      m = (longint'(1) << 40) + longint'(x[9:0]);
        else if (x[14:10] == 5'h00) m = longint'(x[9:0]);
        else                        m = longint'(1024 + int'(x[9:0])) << (int'(x[14:10]) - 1);
        return x[15] ? -m : m;
    endfunction

    function automatic bit nanOf(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'h0);
    endfunction

    task automatic modelOp(input logic [15:0] a, input logic [15:0] b, input int op,
                           output bit flag, output logic [15:0] val, output bit unord);
        longint va = ordKey(a);
        longint vb = ordKey(b);
        flag = 0; val = 16'h0; unord = 0;
        case (op)
            0: flag = (va < vb);
            1: flag = (va == vb);
            2: flag = (va > vb);
            3: flag = (va <= vb);
            4: flag = (va >= vb);
            5: flag = (va != vb);
            6: begin flag = (va <= vb); val = flag ? a : b; end
            default: begin flag = (va >= vb); val = flag ? a : b; end
        endcase
`ifdef FPU_CMP_NAN_EN
        if (nanOf(a) || nanOf(b)) begin
            unord = 1;
            val   = 16'h0;
            flag  = (op == 5);
            if (op >= 6) begin
                if (nanOf(a) && nanOf(b)) begin flag = 0; val = 16'h7E00; end
                else if (nanOf(a))        begin flag = 0; val = b; end
                else                      begin flag = 1; val = a; end
            end
        end
`endif
    endtask

    // One cycle: check outputs against the model, update model, advance to next negedge
    task automatic step(output int acc);
        int          g;
        bit          headReady;
        bit          expAccept;
        logic [NUM_REQ-1:0] expReady;
        bit          f;
        bit          u;
        logic [15:0] v;
        exp_t        e;
        #1;
        g = -1;
        for (int i = 0; i < NUM_REQ; i++) begin
            int k = (rrPtr + i) % NUM_REQ;
            if (g < 0 && reqValid[k]) g = k;
        end
        headReady = (expQ.size() > 0) && (cycleNo >= expQ[0].acc + 2);
        check("rsp_valid", rspValid, headReady);
        if (headReady) begin
            check("rsp_id", rspId, expQ[0].id);
            check("rsp_tag", rspTag, expQ[0].tag);
            check("rsp_flag", rspFlag, expQ[0].flag);
            check("rsp_val", rspVal, expQ[0].val);
            check("rsp_unord", rspUnord, expQ[0].unord);
        end
        expAccept = (g >= 0) && (expQ.size() < 2 || rspReady);
        expReady  = expAccept ? (NUM_REQ'(1) << g) : '0;
        check("req_ready", reqReady, expReady);
        if (headReady && rspReady) void'(expQ.pop_front());
        acc = -1;
        if (expAccept) begin
            modelOp(reqA[g], reqB[g], int'(reqOp[g]), f, v, u);
            e.id = g; e.tag = int'(reqTag[g]); e.flag = f; e.val = v; e.unord = u; e.acc = cycleNo;
            expQ.push_back(e);
            rrPtr = (g + 1) % NUM_REQ;
            acc = g;
        end
        cycleNo++;
        @(negedge clock);
    endtask

    task automatic setReq(input int r, input int op, input logic [15:0] a, input logic [15:0] b, input int tag);
        reqValid[r] = 1'b1;
        reqA[r]     = a;
        reqB[r]     = b;
        reqOp[r]    = 3'(op);
        reqTag[r]   = TAG_W'(tag);
    endtask

    function automatic logic [15:0] pick();
        if ($urandom_range(2) == 0) return specials[$urandom_range(11)];
        return 16'($urandom);
    endfunction

    task automatic randomReq(input int r);
        logic [15:0] a = pick();
        logic [15:0] b = pick();
        if ($urandom_range(7) == 0) b = a;
        setReq(r, int'($urandom_range(7)), a, b, int'($urandom_range(15)));
    endtask

    task automatic checkAllZero(input string name);
        check({name, "_req_ready"}, reqReady, 0);
        check({name, "_rsp_valid"}, rspValid, 0);
        check({name, "_rsp_id"}, rspId, 0);
        check({name, "_rsp_tag"}, rspTag, 0);
        check({name, "_rsp_flag"}, rspFlag, 0);
        check({name, "_rsp_val"}, rspVal, 0);
        check({name, "_rsp_unord"}, rspUnord, 0);
    endtask

    // Issue one op on requester r from an empty pipe and check the response two cycles later
    task automatic single(input string name, input int r, input int op, input logic [15:0] a,
                          input logic [15:0] b, input bit wFlag, input logic [15:0] wVal, input bit wUnord);
        int acc = -1;
        int n = 0;
        rspReady = 1'b1;
        setReq(r, op, a, b, r + 3);
        while (acc != r && n < 8) begin step(acc); n++; end
        check({name, "_accept"}, acc, r);
        reqValid[r] = 1'b0;
        step(acc);
        #1;
        check({name, "_valid"}, rspValid, 1);
        check({name, "_id"}, rspId, r);
        check({name, "_tag"}, rspTag, r + 3);
        check({name, "_flag"}, rspFlag, wFlag);
        check({name, "_val"}, rspVal, wVal);
        check({name, "_unord"}, rspUnord, wUnord);
        step(acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int n;
        int accepts;
        logic [15:0] holdVal;
        logic [TAG_W-1:0] holdTag;

        // Reset state
        #2;
        checkAllZero("reset");
        repeat (3) @(negedge clock);
        reset_L = 1'b1;

        // Single LT op, then zero and NaN corner cases
        single("t1_lt", 0, 0, 16'h3C00, 16'h4000, 1'b1, 16'h0000, 1'b0);
        single("t4_eq_zero", 2, 1, 16'h8000, 16'h0000, 1'b1, 16'h0000, 1'b0);
        single("t4_min", 3, 6, 16'hC000, 16'h3C00, 1'b1, 16'hC000, 1'b0);
        single("t4_max_zero", 1, 7, 16'h0000, 16'h8000, 1'b1, 16'h0000, 1'b0);
`ifdef FPU_CMP_NAN_EN
        single("t5_gt_nan", 0, 2, 16'h7E01, 16'h3C00, 1'b0, 16'h0000, 1'b1);
        single("t5_max_2nan", 1, 7, 16'h7E00, 16'hFE01, 1'b0, 16'h7E00, 1'b1);
        single("t5_ne_nan", 2, 5, 16'h3C00, 16'h7C01, 1'b1, 16'h0000, 1'b1);
`else
        single("t5_gt_nan", 0, 2, 16'h7E01, 16'h3C00, 1'b1, 16'h0000, 1'b0);
        single("t5_max_nan", 1, 7, 16'h7E01, 16'h3C00, 1'b1, 16'h7E01, 1'b0);
`endif

        // Fill both stages under backpressure, then reset asynchronously mid-cycle
        for (int i = 0; i < NUM_REQ; i++) randomReq(i);
        rspReady = 1'b0;
        repeat (3) begin
            step(acc);
            if (acc >= 0) randomReq(acc);
        end
        #2;
        reset_L = 1'b0;
        #1;
        checkAllZero("t6_async");
        expQ.delete();
        rrPtr = 0;
        @(negedge clock);
        @(negedge clock);
        reset_L = 1'b1;

        // All requesters valid: grants rotate 0,1,2,3,0,...
        rspReady = 1'b1;
        for (int k = 0; k < 9; k++) begin
            #1;
            check("t2_grant", reqReady, NUM_REQ'(1) << (k % NUM_REQ));
            step(acc);
            if (acc >= 0) randomReq(acc);
        end

        // Drain, then backpressure from an empty pipe
        reqValid = '0;
        n = 0;
        while (expQ.size() > 0 && n < 10) begin step(acc); n++; end
        check("t3_predrain", expQ.size(), 0);
        for (int i = 0; i < NUM_REQ; i++) randomReq(i);
        rspReady = 1'b0;
        accepts = 0;
        holdVal = 'x;
        holdTag = 'x;
        for (int k = 0; k < 5; k++) begin
            step(acc);
            if (acc >= 0) begin accepts++; randomReq(acc); end
            #1;
            if (k == 2) begin holdVal = rspVal; holdTag = rspTag; end
            if (k > 2) begin
                check("t3_hold_val", rspVal, holdVal);
                check("t3_hold_tag", rspTag, holdTag);
            end
        end
        check("t3_accepts", accepts, 2);
        reqValid = '0;
        rspReady = 1'b1;
        n = 0;
        while (expQ.size() > 0 && n < 10) begin step(acc); n++; end
        check("t3_drained", expQ.size(), 0);
        step(acc);

        // Random traffic with random backpressure
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!reqValid[i] && $urandom_range(99) < 60) randomReq(i);
            end
            rspReady = ($urandom_range(99) < 70);
            step(acc);
            if (acc >= 0) reqValid[acc] = 1'b0;
        end
        reqValid = '0;
        rspReady = 1'b1;
        n = 0;
        while (expQ.size() > 0 && n < 10) begin step(acc); n++; end
        check("final_drained", expQ.size(), 0);
        step(acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
